// File: rtl/ts_sync_aligner.sv
// MPEG-2 TS sync aligner: hunts for SYNC_BYTE at PKT_LEN spacing, locks, and forwards aligned bytes.
// Optional sync-loss counter port enabled by defining TS_SYNC_LOSS_COUNT_EN.
module ts_sync_aligner #(
    parameter int unsigned PKT_LEN    = 188,
    parameter logic [7:0]  SYNC_BYTE  = 8'h47,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       en_reset_counter,
    output logic       valid,
    output logic       sync,
    output logic [7:0] ts_data,
`ifdef TS_SYNC_LOSS_COUNT_EN
    output logic [7:0] sync_loss_count,
`endif
    output logic       locked
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST   = 8'(PKT_LEN - 1);
    localparam logic [3:0] LP_LOCK   = 4'(LOCK_CNT);
    localparam logic [3:0] LP_UNLOCK = 4'(UNLOCK_CNT);

    state_t     r_state;
    logic [7:0] r_pos;
    logic [3:0] r_hits;
    logic [3:0] r_miss;
    logic       r_valid;
    logic       r_sync;
    logic [7:0] r_data;
    logic       r_locked;

    state_t     w_state_nxt;
    logic [7:0] w_pos_nxt;
    logic [3:0] w_hits_nxt;
    logic [3:0] w_miss_nxt;
    logic       w_out_valid;
    logic       w_out_sync;
    logic       w_loss_evt;
    logic       w_at0;
    logic       w_is_sync;
    logic [7:0] w_pos_inc;
    logic [3:0] w_hits_inc;
    logic [3:0] w_miss_inc;

    assign w_at0      = (r_pos == 8'd0);
    assign w_is_sync  = (in_data == SYNC_BYTE);
    assign w_pos_inc  = (r_pos == LP_LAST) ? 8'd0 : 8'(r_pos + 8'd1);
    assign w_hits_inc = 4'(r_hits + 4'd1);
    assign w_miss_inc = 4'(r_miss + 4'd1);

    // pos always names the packet position of the next in_valid byte.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_hits_nxt  = r_hits;
        w_miss_nxt  = r_miss;
        w_out_valid = 1'b0;
        w_out_sync  = 1'b0;
        w_loss_evt  = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    if (w_is_sync) begin
                        w_state_nxt = VERIFY;
                        w_pos_nxt   = 8'd1;
                        w_hits_nxt  = 4'd1;
                    end
                end
                VERIFY: begin
                    w_pos_nxt = w_pos_inc;
                    if (w_at0) begin
                        if (w_is_sync) begin
                            w_hits_nxt = w_hits_inc;
                            if (w_hits_inc == LP_LOCK) begin
                                w_state_nxt = LOCK;
                                w_miss_nxt  = 4'd0;
                                w_out_valid = 1'b1;
                                w_out_sync  = 1'b1;
                            end
                        end else begin
                            w_state_nxt = HUNT;
                            w_pos_nxt   = 8'd0;
                            w_hits_nxt  = 4'd0;
                        end
                    end
                end
                LOCK: begin
                    w_pos_nxt   = w_pos_inc;
                    w_out_valid = 1'b1;
                    w_out_sync  = w_at0;
                    if (w_at0) begin
                        if (w_is_sync) begin
                            w_miss_nxt = 4'd0;
                        end else if (w_miss_inc == LP_UNLOCK) begin
                            // Final miss: drop this byte and restart the hunt.
                            w_state_nxt = HUNT;
                            w_pos_nxt   = 8'd0;
                            w_hits_nxt  = 4'd0;
                            w_miss_nxt  = 4'd0;
                            w_out_valid = 1'b0;
                            w_out_sync  = 1'b0;
                            w_loss_evt  = 1'b1;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_pos_nxt   = 8'd0;
                    w_hits_nxt  = 4'd0;
                    w_miss_nxt  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= HUNT;
            r_pos    <= 8'd0;
            r_hits   <= 4'd0;
            r_miss   <= 4'd0;
            r_valid  <= 1'b0;
            r_sync   <= 1'b0;
            r_data   <= 8'h00;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_hits   <= w_hits_nxt;
            r_miss   <= w_miss_nxt;
            r_valid  <= w_out_valid;
            r_sync   <= w_out_sync;
            r_locked <= (w_state_nxt == LOCK);
            if (w_out_valid) begin
                r_data <= in_data;
            end
        end
    end

    assign valid   = r_valid;
    assign sync    = r_sync;
    assign ts_data = r_data;
    assign locked  = r_locked;

`ifdef TS_SYNC_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;

    // Clear wins over a coincident loss event; count saturates at 0xFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= 8'd0;
        end else if (en_reset_counter) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= 8'(r_loss_cnt + 8'd1);
        end
    end

    assign sync_loss_count = r_loss_cnt;
`else
    logic w_unused;
    assign w_unused = en_reset_counter ^ w_loss_evt;
`endif

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Scoreboard bench for ts_sync_aligner: a reference framer predicts each cycle's outputs.
module tb_ts_sync_aligner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       en_reset_counter;
    logic       valid;
    logic       sync;
    logic [7:0] ts_data;
    logic       locked;
`ifdef TS_SYNC_LOSS_COUNT_EN
    logic [7:0] sync_loss_count;
`endif

    ts_sync_aligner dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .en_reset_counter (en_reset_counter),
        .valid            (valid),
        .sync             (sync),
        .ts_data          (ts_data),
`ifdef TS_SYNC_LOSS_COUNT_EN
        .sync_loss_count  (sync_loss_count),
`endif
        .locked           (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       l;
        logic [7:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference framer: mode 0=hunt 1=verify 2=lock; idx = bytes seen in current packet.
    int         m_mode = 0;
    int         m_idx  = 0;
    int         m_hits = 0;
    int         m_miss = 0;
    logic       m_v    = 1'b0;
    logic       m_s    = 1'b0;
    logic [7:0] m_d    = 8'h00;
    int         m_loss = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_hits = 0; m_miss = 0;
        m_v = 1'b0; m_s = 1'b0; m_d = 8'h00; m_loss = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
        bit lost;
        lost = 0;
        m_v = 1'b0;
        m_s = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
                if (d == 8'h47) begin
                    m_mode = 1; m_idx = 1; m_hits = 1;
                end
            end else if (m_mode == 1) begin
                if (m_idx == 0 && d != 8'h47) begin
                    m_mode = 0; m_hits = 0; m_idx = 0;
                end else begin
                    if (m_idx == 0) begin
                        m_hits++;
                        if (m_hits == 3) begin
                            m_mode = 2; m_miss = 0;
                            m_v = 1'b1; m_s = 1'b1; m_d = d;
                        end
                    end
                    m_idx = (m_idx + 1) % 188;
                end
            end else begin
                if (m_idx == 0 && d != 8'h47 && m_miss == 2) begin
                    m_mode = 0; m_idx = 0; m_miss = 0; m_hits = 0;
                    lost = 1;
                end else begin
                    if (m_idx == 0) m_miss = (d == 8'h47) ? 0 : m_miss + 1;
                    m_v = 1'b1; m_s = (m_idx == 0); m_d = d;
                    m_idx = (m_idx + 1) % 188;
                end
            end
        end
        if (clr) m_loss = 0;
        else if (lost && m_loss < 255) m_loss++;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        exp_t e;
        in_valid = v;
        in_data  = d;
        model_step(v, d, en_reset_counter);
        e.v = m_v; e.s = m_s; e.d = m_d; e.l = (m_mode == 2); e.c = 8'(m_loss);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pay();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h47) b = 8'h46;
        return b;
    endfunction

    task automatic send_pkt(input logic [7:0] sb, input bit gap, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            drive(1'b1, (i == 0) ? sb : pay());
            if (gap) drive(1'b0, pay());
        end
    endtask

    task automatic do_reset();
        #2;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("rst_valid",  32'(valid),   32'd0);
        chk("rst_sync",   32'(sync),    32'd0);
        chk("rst_data",   32'(ts_data), 32'd0);
        chk("rst_locked", 32'(locked),  32'd0);
`ifdef TS_SYNC_LOSS_COUNT_EN
        chk("rst_count",  32'(sync_loss_count), 32'd0);
`endif
        model_reset();
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid",   32'(valid),   32'(e.v));
            chk("sync",    32'(sync),    32'(e.s));
            chk("ts_data", 32'(ts_data), 32'(e.d));
            chk("locked",  32'(locked),  32'(e.l));
`ifdef TS_SYNC_LOSS_COUNT_EN
            chk("loss_cnt", 32'(sync_loss_count), 32'(e.c));
`endif
        end
    end

    initial begin
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_data          = 8'h00;
        en_reset_counter = 1'b0;
        #12;
        do_reset();

        // Clean stream: lock on packet 3 byte 0.
        for (int p = 0; p < 10; p++) send_pkt(8'h47, 1'b0, 188);
        chk("locked_after_clean", 32'(locked), 32'd1);

        // Payload 0x47 while locked is ignored.
        drive(1'b1, 8'h47);
        for (int i = 1; i < 188; i++) drive(1'b1, (i == 60) ? 8'h47 : pay());

        // Flywheel: two bad syncs, then good ones.
        send_pkt(8'h00, 1'b0, 188);
        send_pkt(8'h00, 1'b0, 188);
        chk("flywheel_locked", 32'(locked), 32'd1);
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 1'b0, 188);

        // Loss of sync on third bad sync, then relock.
        for (int p = 0; p < 3; p++) send_pkt(8'h00, 1'b0, 188);
        chk("loss_unlocked", 32'(locked), 32'd0);
        for (int p = 0; p < 4; p++) send_pkt(8'h47, 1'b0, 188);
        chk("relocked", 32'(locked), 32'd1);

        // Gapped input.
        for (int p = 0; p < 5; p++) send_pkt(8'h47, 1'b1, 188);

        // Reset mid-packet while locked.
        send_pkt(8'h47, 1'b0, 100);
        do_reset();

        // False sync at offset 50, resolved before the true stream starts.
        for (int i = 0; i < 240; i++) drive(1'b1, (i == 50) ? 8'h47 : pay());
        for (int p = 0; p < 5; p++) send_pkt(8'h47, 1'b0, 188);
        chk("false_sync_locked", 32'(locked), 32'd1);

        // Five loss events, then counter clear.
        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < 3; p++) send_pkt(8'h00, 1'b0, 188);
            for (int p = 0; p < 4; p++) send_pkt(8'h47, 1'b0, 188);
        end
`ifdef TS_SYNC_LOSS_COUNT_EN
        chk("count_before_clear", 32'(sync_loss_count), 32'd5);
`endif
        en_reset_counter = 1'b1;
        drive(1'b0, 8'h00);
        en_reset_counter = 1'b0;
        drive(1'b0, 8'h00);
`ifdef TS_SYNC_LOSS_COUNT_EN
        chk("count_after_clear", 32'(sync_loss_count), 32'd0);
`endif
        chk("clear_keeps_lock", 32'(locked), 32'd1);

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
